proc_sequencer: RTL

PROC_SEQUENCER -- requirements
Module: proc_sequencer

---
 rtl/proc_pkg.sv | 68 ++++++
 rtl/exec_watchdog.sv | 45 ++++
 rtl/proc_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared sequencer/datapath encodings and instruction field layout
//
// Purpose: state encoding for the instruction sequencer, bit positions of the
//          instruction fields, opcode constants and small field-extract helpers.
//          Imported by proc_sequencer, exec_watchdog and the ALU/GPR datapath.
// Ports:   none (package).
package proc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_DECODE    = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_NEXT      = 3'd5,
        ST_HALT      = 3'd6
    } seq_state_e;

    // Instruction field positions. rsrc2 and isrc overlap: imm_mode selects
    // which interpretation the datapath uses.
    localparam int OPER_MSB     = 31;
    localparam int OPER_LSB     = 27;
    localparam int RDST_MSB     = 26;
    localparam int RDST_LSB     = 22;
    localparam int RSRC1_MSB    = 21;
    localparam int RSRC1_LSB    = 17;
    localparam int IMM_MODE_BIT = 16;
    localparam int RSRC2_MSB    = 15;
    localparam int RSRC2_LSB    = 11;
    localparam int ISRC_MSB     = 15;
    localparam int ISRC_LSB     = 0;

    localparam int OPER_W = OPER_MSB - OPER_LSB + 1;

    localparam logic [OPER_W-1:0] OP_MOV  = 5'd0;
    localparam logic [OPER_W-1:0] OP_ADD  = 5'd1;
    localparam logic [OPER_W-1:0] OP_SUB  = 5'd2;
    localparam logic [OPER_W-1:0] OP_AND  = 5'd3;
    localparam logic [OPER_W-1:0] OP_OR   = 5'd4;
    localparam logic [OPER_W-1:0] OP_XOR  = 5'd5;
    localparam logic [OPER_W-1:0] OP_MOVI = 5'd6;
    localparam logic [OPER_W-1:0] OP_HALT = 5'b11111;

    function automatic logic [OPER_W-1:0] get_oper_type(input logic [31:0] inst);
        return inst[OPER_MSB:OPER_LSB];
    endfunction

    function automatic logic [4:0] get_rdst(input logic [31:0] inst);
        return inst[RDST_MSB:RDST_LSB];
    endfunction

    function automatic logic [4:0] get_rsrc1(input logic [31:0] inst);
        return inst[RSRC1_MSB:RSRC1_LSB];
    endfunction

    function automatic logic [4:0] get_rsrc2(input logic [31:0] inst);
        return inst[RSRC2_MSB:RSRC2_LSB];
    endfunction

    function automatic logic get_imm_mode(input logic [31:0] inst);
        return inst[IMM_MODE_BIT];
    endfunction

    function automatic logic [15:0] get_isrc(input logic [31:0] inst);
        return inst[ISRC_MSB:ISRC_LSB];
    endfunction

endpackage

// File: rtl/exec_watchdog.sv
// rtl/exec_watchdog.sv - cycle counter that bounds how long the datapath may take
//
// Purpose: counts cycles while enable is high; expired rises on the TIMEOUT-th
//          enabled cycle so the caller can abort in that same cycle.
// Ports:   clk, sys_rst (sync, active-high), clear (zero the count),
//          enable (count this cycle), expired (TIMEOUT-th enabled cycle).
module exec_watchdog
    import proc_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt_q holds the number of enabled cycles already completed, so the
    // current cycle is number cnt_q+1.
    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/proc_sequencer.sv
// rtl/proc_sequencer.sv - fetch/decode/execute sequencer for the ALU/GPR datapath
//
// Purpose: fetches 32-bit instructions from a one-cycle-latency instruction
//          memory, hands each to the datapath with a one-cycle exec_en pulse,
//          waits for exec_done (bounded by a watchdog), and stops on HALT_OP.
// Ports:   clk, sys_rst (sync, active-high), start (run from pc=0 when idle/halted),
//          imem_addr/imem_rd/imem_rdata (instruction memory), ir (instruction
//          register), exec_en/exec_done (datapath handshake), pc, busy, halted,
//          err (sticky timeout), inst_cnt (retired instructions, saturating).
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int                PC_W    = 8,
    parameter int                TIMEOUT = 15,
    parameter logic [OPER_W-1:0] HALT_OP = OP_HALT
) (
    input  logic            clk,
    input  logic            sys_rst,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    output logic            exec_en,
    input  logic            exec_done,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            err,
    output logic [15:0]     inst_cnt
);

    seq_state_e      state_q,    state_d;
    logic [PC_W-1:0] pc_q,       pc_d;
    logic [31:0]     ir_q,       ir_d;
    logic [15:0]     inst_cnt_q, inst_cnt_d;
    logic            err_q,      err_d;

    logic            wd_enable;
    logic            wd_clear;
    logic            wd_expired;

    assign wd_enable = (state_q == ST_WAIT_DONE);
    assign wd_clear  = (state_q != ST_WAIT_DONE);

    exec_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_exec_watchdog (
        .clk     (clk),
        .sys_rst (sys_rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        inst_cnt_d = inst_cnt_q;
        err_d      = err_q;
        imem_rd    = 1'b0;
        exec_en    = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                // Restart from either resting state; pc, ir and inst_cnt are
                // otherwise frozen here.
                if (start) begin
                    pc_d       = '0;
                    inst_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_rd = 1'b1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                ir_d    = imem_rdata;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (get_oper_type(ir_q) == HALT_OP) begin
                    state_d = ST_HALT;
                end else begin
                    exec_en = 1'b1;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // A completion in the final allowed cycle still counts.
                if (exec_done) begin
                    state_d = ST_NEXT;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_NEXT: begin
                pc_d = pc_q + PC_W'(1);
                if (inst_cnt_q != 16'hFFFF) begin
                    inst_cnt_d = inst_cnt_q + 16'd1;
                end
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            inst_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            inst_cnt_q <= inst_cnt_d;
            err_q      <= err_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign inst_cnt  = inst_cnt_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted    = (state_q == ST_HALT);

endmodule
